// File: rtl/fp16_mult_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : fp16_mult_arbiter                                                |
// | Purpose : Round-robin sharing of one pipelined FP16 multiplier among       |
// |           NUM_REQ requesters, with tag-tracked result return.              |
// | Rev     : 1.0                                                              |
// +----------------------------------------------------------------------------+
module fp16_mult_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int MULT_LATENCY = 3,
  parameter int DWIDTH       = 16,
  parameter int IDW          = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_arb_en,
  input  logic [NUM_REQ-1:0]        i_req_valid,
  output logic [NUM_REQ-1:0]        o_req_ready,
  input  logic [NUM_REQ*DWIDTH-1:0] i_req_a,
  input  logic [NUM_REQ*DWIDTH-1:0] i_req_b,
  output logic                      o_mul_en,
  output logic [DWIDTH-1:0]         o_mul_a,
  output logic [DWIDTH-1:0]         o_mul_b,
  input  logic [DWIDTH-1:0]         i_mul_result,
  input  logic [4:0]                i_mul_flags,
  input  logic                      i_mul_valid,
  output logic [NUM_REQ-1:0]        o_rsp_valid,
  output logic [DWIDTH-1:0]         o_rsp_result,
  output logic [4:0]                o_rsp_flags,
  output logic [IDW-1:0]            o_rsp_id,
  output logic [IDW+2:0]            o_inflight,
  output logic                      o_sync_err
);

  logic [IDW-1:0]    r_rr_ptr;
  logic              r_mul_en;
  logic [DWIDTH-1:0] r_mul_a;
  logic [DWIDTH-1:0] r_mul_b;
  logic [MULT_LATENCY:0] r_tag_v;          // bit 0 = issue tag, top bit = tail
  logic [IDW-1:0]    r_tag_id [0:MULT_LATENCY];
  logic [IDW+2:0]    r_inflight;
  logic              r_sync_err;

  logic [NUM_REQ-1:0] w_grant;
  logic [IDW-1:0]     w_gid;
  logic               w_xfer;
  logic [IDW:0]       w_idx;
  logic               w_tail_v;
  logic [IDW-1:0]     w_tail_id;

  // Circular search starting at r_rr_ptr; the first valid requester wins.
  always_comb begin
    w_grant = '0;
    w_gid   = '0;
    w_xfer  = 1'b0;
    w_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = {1'b0, r_rr_ptr} + (IDW+1)'(k);
      if (w_idx >= (IDW+1)'(NUM_REQ)) w_idx = w_idx - (IDW+1)'(NUM_REQ);
      if (!w_xfer && i_arb_en && !rst && i_req_valid[w_idx[IDW-1:0]]) begin
        w_grant[w_idx[IDW-1:0]] = 1'b1;
        w_gid                   = w_idx[IDW-1:0];
        w_xfer                  = 1'b1;
      end
    end
  end

  assign w_tail_v  = r_tag_v[MULT_LATENCY];
  assign w_tail_id = r_tag_id[MULT_LATENCY];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr <= '0;
      r_mul_en <= 1'b0;
      r_mul_a  <= '0;
      r_mul_b  <= '0;
    end else begin
      r_mul_en <= w_xfer;
      if (w_xfer) begin
        r_mul_a  <= i_req_a[int'(w_gid)*DWIDTH +: DWIDTH];
        r_mul_b  <= i_req_b[int'(w_gid)*DWIDTH +: DWIDTH];
        r_rr_ptr <= (w_gid == IDW'(NUM_REQ-1)) ? '0 : w_gid + 1'b1;
      end
    end
  end

  // The multiplier never stalls, so the tag pipe shifts every cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tag_v <= '0;
      for (int k = 0; k <= MULT_LATENCY; k++) r_tag_id[k] <= '0;
    end else begin
      r_tag_v     <= {r_tag_v[MULT_LATENCY-1:0], w_xfer};
      r_tag_id[0] <= w_gid;
      for (int k = 1; k <= MULT_LATENCY; k++) r_tag_id[k] <= r_tag_id[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_inflight <= '0;
      r_sync_err <= 1'b0;
    end else begin
      case ({w_xfer, w_tail_v})
        2'b10:   r_inflight <= r_inflight + 1'b1;
        2'b01:   r_inflight <= r_inflight - 1'b1;
        default: r_inflight <= r_inflight;
      endcase
      if (i_mul_valid != w_tail_v) r_sync_err <= 1'b1;
    end
  end

  always_comb begin
    o_rsp_valid = '0;
    if (w_tail_v) o_rsp_valid[w_tail_id] = 1'b1;
  end

  assign o_req_ready  = w_grant;
  assign o_mul_en     = r_mul_en;
  assign o_mul_a      = r_mul_a;
  assign o_mul_b      = r_mul_b;
  assign o_rsp_result = i_mul_result;
  assign o_rsp_flags  = i_mul_flags;
  assign o_rsp_id     = w_tail_id;
  assign o_inflight   = r_inflight;
  assign o_sync_err   = r_sync_err;

endmodule
`default_nettype wire

// File: tb/tb_fp16_mult_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_fp16_mult_arbiter                                             |
// | Purpose : Self-checking bench with a 3-stage FP16 multiplier stand-in and  |
// |           a queue-based reference model of arbitration and result return.  |
// | Rev     : 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_fp16_mult_arbiter;
  localparam int N = 4;
  localparam int L = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          arb_en = 1'b0;
  logic [N-1:0]  req_valid = '0;
  logic [N*16-1:0] req_a = '0;
  logic [N*16-1:0] req_b = '0;
  logic [N-1:0]  req_ready;
  logic          mul_en;
  logic [15:0]   mul_a, mul_b, mul_result;
  logic [4:0]    mul_flags;
  logic          mul_valid;
  logic [N-1:0]  rsp_valid;
  logic [15:0]   rsp_result;
  logic [4:0]    rsp_flags;
  logic [1:0]    rsp_id;
  logic [4:0]    inflight;
  logic          sync_err;
  logic          inj = 1'b0;

  fp16_mult_arbiter #(.NUM_REQ(N), .MULT_LATENCY(L), .DWIDTH(16)) dut (
    .clk(clk), .rst(rst), .i_arb_en(arb_en), .i_req_valid(req_valid),
    .o_req_ready(req_ready), .i_req_a(req_a), .i_req_b(req_b),
    .o_mul_en(mul_en), .o_mul_a(mul_a), .o_mul_b(mul_b),
    .i_mul_result(mul_result), .i_mul_flags(mul_flags), .i_mul_valid(mul_valid),
    .o_rsp_valid(rsp_valid), .o_rsp_result(rsp_result), .o_rsp_flags(rsp_flags),
    .o_rsp_id(rsp_id), .o_inflight(inflight), .o_sync_err(sync_err));

  always #5 clk = ~clk;

  // Normal-range FP16 product, mantissa truncated.
  function automatic logic [15:0] fmul(input logic [15:0] a, input logic [15:0] b);
    logic [21:0] p;
    int e;
    logic [9:0] m;
    logic [4:0] e5;
    p = {1'b1, a[9:0]} * {1'b1, b[9:0]};
    e = int'(a[14:10]) + int'(b[14:10]) - 15;
    if (p[21]) begin m = p[20:11]; e = e + 1; end
    else m = p[19:10];
    e5 = 5'(e);
    return {a[15] ^ b[15], e5, m};
  endfunction

  function automatic logic [15:0] rand_fp();
    logic [15:0] r;
    r[15]    = 1'($urandom);
    r[14:10] = 5'($urandom_range(10, 20));
    r[9:0]   = 10'($urandom);
    return r;
  endfunction

  // Multiplier stand-in: 3 registered stages, shares rst.
  logic [15:0] pa [0:2];
  logic [15:0] pb [0:2];
  logic [2:0]  pv;
  always @(posedge clk) begin
    if (rst) begin
      pv <= '0;
      for (int k = 0; k < 3; k++) begin pa[k] <= '0; pb[k] <= '0; end
    end else begin
      pv <= {pv[1:0], mul_en};
      pa[0] <= mul_a; pb[0] <= mul_b;
      for (int k = 1; k < 3; k++) begin pa[k] <= pa[k-1]; pb[k] <= pb[k-1]; end
    end
  end
  assign mul_valid  = pv[2] | inj;
  assign mul_result = fmul(pa[2], pb[2]);
  assign mul_flags  = pa[2][4:0] ^ pb[2][4:0];

  // Reference model: accepted ops wait in a queue tagged with their due cycle.
  typedef struct { int due; int id; logic [15:0] a; logic [15:0] b; } op_t;
  op_t q[$];
  int m_ptr = 0, m_cyc = 0;
  logic m_mul_en = 1'b0;
  logic [15:0] m_mul_a = '0, m_mul_b = '0;
  logic [N-1:0] e_ready, e_rsp_valid;
  int e_gid, e_rsp_id;
  logic [15:0] e_rsp_res;
  logic [4:0] e_rsp_flg, e_inflight;
  int n_checks = 0, n_fail = 0;

  task automatic model_eval();
    bit found;
    int idx;
    found = 0; e_ready = '0; e_gid = 0;
    if (arb_en && !rst)
      for (int k = 0; k < N; k++) begin
        idx = (m_ptr + k) % N;
        if (!found && req_valid[idx]) begin e_ready[idx] = 1'b1; e_gid = idx; found = 1; end
      end
    e_rsp_valid = '0; e_rsp_id = 0; e_rsp_res = '0; e_rsp_flg = '0;
    if (q.size() > 0 && q[0].due == m_cyc) begin
      e_rsp_valid[q[0].id] = 1'b1;
      e_rsp_id  = q[0].id;
      e_rsp_res = fmul(q[0].a, q[0].b);
      e_rsp_flg = q[0].a[4:0] ^ q[0].b[4:0];
    end
    e_inflight = 5'(q.size());
  endtask

  task automatic model_commit();
    op_t o;
    if (rst) begin
      q.delete(); m_ptr = 0; m_mul_en = 1'b0; m_mul_a = '0; m_mul_b = '0;
    end else begin
      if (q.size() > 0 && q[0].due == m_cyc) void'(q.pop_front());
      if (e_ready != '0) begin
        o.due = m_cyc + 1 + L; o.id = e_gid;
        o.a = req_a[e_gid*16 +: 16]; o.b = req_b[e_gid*16 +: 16];
        q.push_back(o);
        m_ptr = (e_gid + 1) % N;
        m_mul_en = 1'b1; m_mul_a = o.a; m_mul_b = o.b;
      end else m_mul_en = 1'b0;
    end
    m_cyc++;
  endtask

  task automatic sample();  #1; model_eval();  endtask
  task automatic advance(); model_commit(); @(negedge clk); endtask

  task automatic rand_operands();
    for (int i = 0; i < N; i++) begin
      req_a[i*16 +: 16] = rand_fp();
      req_b[i*16 +: 16] = rand_fp();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; arb_en = 1'b1; req_valid = '1; rand_operands();
    for (int c = 0; c < 2; c++) begin
      sample();
      n_checks++; if (req_ready !== '0) begin n_fail++; $display("FAIL reset_ready got=%b exp=0000", req_ready); end
      advance();
    end
    rst = 1'b0; req_valid = '0; sample();
    n_checks++; if (mul_en !== 1'b0) begin n_fail++; $display("FAIL reset_mul_en got=%b exp=0", mul_en); end
    n_checks++; if ({mul_a, mul_b} !== 32'h0) begin n_fail++; $display("FAIL reset_mul_ab got=%h%h exp=0", mul_a, mul_b); end
    n_checks++; if (rsp_valid !== '0 || rsp_id !== 2'd0) begin n_fail++; $display("FAIL reset_rsp got=%b/%0d exp=0000/0", rsp_valid, rsp_id); end
    n_checks++; if (inflight !== 5'd0 || sync_err !== 1'b0) begin n_fail++; $display("FAIL reset_cnt got=%0d/%b exp=0/0", inflight, sync_err); end
    advance();
  endtask

  task automatic test_single_op();
    req_valid = 4'b0100; req_a[32 +: 16] = 16'h3E00; req_b[32 +: 16] = 16'h4000; sample();
    n_checks++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL single_ready got=%b exp=0100", req_ready); end
    advance(); req_valid = '0;
    for (int c = 1; c <= 5; c++) begin
      sample();
      if (c == 1) begin
        n_checks++; if (mul_en !== 1'b1 || mul_a !== 16'h3E00 || mul_b !== 16'h4000) begin
          n_fail++; $display("FAIL single_mul got=%b %h %h exp=1 3e00 4000", mul_en, mul_a, mul_b); end
      end
      if (c == 4) begin
        n_checks++; if (rsp_valid !== 4'b0100 || rsp_result !== 16'h4200 || rsp_id !== 2'd2) begin
          n_fail++; $display("FAIL single_rsp got=%b %h %0d exp=0100 4200 2", rsp_valid, rsp_result, rsp_id); end
      end else begin
        n_checks++; if (rsp_valid !== '0) begin n_fail++; $display("FAIL single_idle c=%0d got=%b exp=0000", c, rsp_valid); end
      end
      advance();
    end
  endtask

  task automatic test_round_robin();
    int max_inf;
    max_inf = 0;
    rst = 1'b1; sample(); advance(); rst = 1'b0;
    for (int c = 0; c < 14; c++) begin
      req_valid = (c < 8) ? 4'b1111 : 4'b0000; rand_operands(); sample();
      if (c < 8) begin
        n_checks++; if (req_ready !== 4'(1 << (c % 4)) || req_ready !== e_ready) begin
          n_fail++; $display("FAIL rr_grant c=%0d got=%b exp=%b", c, req_ready, e_ready); end
      end
      if (c >= 4 && c < 12) begin
        n_checks++; if (rsp_valid !== e_rsp_valid || rsp_id !== 2'((c - 4) % 4) || rsp_result !== e_rsp_res) begin
          n_fail++; $display("FAIL rr_rsp c=%0d got=%b %0d %h exp=%b %0d %h", c, rsp_valid, rsp_id, rsp_result, e_rsp_valid, (c-4)%4, e_rsp_res); end
      end
      if (int'(inflight) > max_inf) max_inf = int'(inflight);
      advance();
    end
    n_checks++; if (max_inf !== 4) begin n_fail++; $display("FAIL rr_inflight_max got=%0d exp=4", max_inf); end
  endtask

  task automatic test_single_then_join();
    logic [N-1:0] exp;
    for (int c = 0; c < 16; c++) begin
      req_valid = (c < 5) ? 4'b0010 : (c < 11) ? 4'b1010 : 4'b0000; rand_operands(); sample();
      exp = (c < 5) ? 4'b0010 : (c >= 11) ? 4'b0000 : (((c - 5) % 2) == 0) ? 4'b1000 : 4'b0010;
      n_checks++; if (req_ready !== exp) begin n_fail++; $display("FAIL join_grant c=%0d got=%b exp=%b", c, req_ready, exp); end
      n_checks++; if (rsp_valid !== e_rsp_valid || (|e_rsp_valid && rsp_result !== e_rsp_res)) begin
        n_fail++; $display("FAIL join_rsp c=%0d got=%b %h exp=%b %h", c, rsp_valid, rsp_result, e_rsp_valid, e_rsp_res); end
      advance();
    end
  endtask

  task automatic test_arb_en();
    int last_id;
    last_id = 0;
    for (int c = 0; c < 13; c++) begin
      arb_en = !(c == 3 || c == 4); req_valid = (c < 8) ? 4'b1111 : 4'b0000; rand_operands(); sample();
      n_checks++; if (req_ready !== e_ready) begin n_fail++; $display("FAIL en_grant c=%0d got=%b exp=%b", c, req_ready, e_ready); end
      if (c == 2) last_id = e_gid;
      if (c == 3 || c == 4) begin
        n_checks++; if (req_ready !== '0) begin n_fail++; $display("FAIL en_off_ready c=%0d got=%b exp=0000", c, req_ready); end
      end
      if (c == 4) begin
        n_checks++; if (mul_en !== 1'b0) begin n_fail++; $display("FAIL en_off_mul_en got=%b exp=0", mul_en); end
      end
      if (c == 5) begin
        n_checks++; if (req_ready !== 4'(1 << ((last_id + 1) % 4))) begin
          n_fail++; $display("FAIL en_resume got=%b exp_id=%0d", req_ready, (last_id + 1) % 4); end
      end
      n_checks++; if (rsp_valid !== e_rsp_valid || mul_en !== m_mul_en) begin
        n_fail++; $display("FAIL en_rsp c=%0d got=%b/%b exp=%b/%b", c, rsp_valid, mul_en, e_rsp_valid, m_mul_en); end
      advance();
    end
    arb_en = 1'b1;
  endtask

  task automatic test_reset_midflight();
    for (int c = 0; c < 11; c++) begin
      req_valid = (c < 3) ? 4'b0001 : 4'b0000; rst = (c == 3); rand_operands(); sample();
      if (c == 3) begin
        n_checks++; if (inflight !== 5'd3) begin n_fail++; $display("FAIL rstmid_pre got=%0d exp=3", inflight); end
      end
      if (c > 3) begin
        n_checks++; if (rsp_valid !== '0 || inflight !== 5'd0 || sync_err !== 1'b0) begin
          n_fail++; $display("FAIL rstmid c=%0d got=%b %0d %b exp=0000 0 0", c, rsp_valid, inflight, sync_err); end
      end
      advance();
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 306; c++) begin
      arb_en = ($urandom_range(0, 7) != 0);
      req_valid = (c < 300) ? 4'($urandom) : 4'b0000; rand_operands(); sample();
      n_checks++; if (req_ready !== e_ready) begin n_fail++; $display("FAIL rnd_grant c=%0d got=%b exp=%b", c, req_ready, e_ready); end
      n_checks++; if (mul_en !== m_mul_en || mul_a !== m_mul_a || mul_b !== m_mul_b) begin
        n_fail++; $display("FAIL rnd_mul c=%0d got=%b %h %h exp=%b %h %h", c, mul_en, mul_a, mul_b, m_mul_en, m_mul_a, m_mul_b); end
      n_checks++; if (rsp_valid !== e_rsp_valid || inflight !== e_inflight || sync_err !== 1'b0) begin
        n_fail++; $display("FAIL rnd_state c=%0d got=%b %0d %b exp=%b %0d 0", c, rsp_valid, inflight, sync_err, e_rsp_valid, e_inflight); end
      if (e_rsp_valid != '0) begin
        n_checks++; if (rsp_id !== 2'(e_rsp_id) || rsp_result !== e_rsp_res || rsp_flags !== e_rsp_flg) begin
          n_fail++; $display("FAIL rnd_rsp c=%0d got=%0d %h %h exp=%0d %h %h", c, rsp_id, rsp_result, rsp_flags, e_rsp_id, e_rsp_res, e_rsp_flg); end
      end
      advance();
    end
  endtask

  task automatic test_sync_err();
    req_valid = '0; inj = 1'b1; sample();
    n_checks++; if (sync_err !== 1'b0) begin n_fail++; $display("FAIL sync_pre got=%b exp=0", sync_err); end
    advance(); inj = 1'b0;
    for (int c = 0; c < 4; c++) begin
      sample();
      n_checks++; if (sync_err !== 1'b1) begin n_fail++; $display("FAIL sync_sticky c=%0d got=%b exp=1", c, sync_err); end
      advance();
    end
    rst = 1'b1; sample(); advance(); rst = 1'b0; sample();
    n_checks++; if (sync_err !== 1'b0) begin n_fail++; $display("FAIL sync_clear got=%b exp=0", sync_err); end
    advance();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_single_op();
    test_round_robin();
    test_single_then_join();
    test_arb_en();
    test_reset_midflight();
    test_random();
    test_sync_err();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/fp16_mult_arbiter.md
# fp16_mult_arbiter

Round-robin arbiter that shares one pipelined FP16 multiplier (`FPMult_16`, 3-cycle `en`→`valid` latency) among `NUM_REQ` requesters. It accepts one operand pair per cycle over a valid/ready handshake and registers the pair into the multiplier inputs. A tag shift register aligned to the multiplier latency tracks the requester ID of each in-flight operation. Each result is returned to its originating requester with a one-hot valid strobe. The block sits between the tensor-lane issue logic and the single shared multiplier instance.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters, 2..8.
- `MULT_LATENCY`, 3: cycles from `mul_en` high to matching `mul_valid` high.
- `DWIDTH`, 16: operand width.
- `IDW`, `$clog2(NUM_REQ)`: width of the requester ID.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `arb_en`  in  1  grants are allowed only when high; in-flight operations still drain.
- `req_valid`  in  NUM_REQ  per-requester operand pair valid.
- `req_ready`  out  NUM_REQ  one-hot grant; at most one bit high.
- `req_a`  in  NUM_REQ*DWIDTH  operand A; requester i occupies bits [i*DWIDTH +: DWIDTH].
- `req_b`  in  NUM_REQ*DWIDTH  operand B; same packing as `req_a`.
- `mul_en`, `mul_a`, `mul_b`  out  1, DWIDTH, DWIDTH  registered drive to the multiplier.
- `mul_result`, `mul_flags`, `mul_valid`  in  DWIDTH, 5, 1  multiplier outputs.
- `rsp_valid`  out  NUM_REQ  one-hot result strobe.
- `rsp_result`, `rsp_flags`, `rsp_id`  out  DWIDTH, 5, IDW  result, flags and requester ID, shared by all requesters.
- `inflight`  out  IDW+3  number of in-flight operations.
- `sync_err`  out  1  sticky error: `mul_valid` disagreed with the tag pipeline.

## Operation
- Grant logic is combinational. `req_ready[i]` = 1 when all of these hold:
  - `arb_en` = 1 and `rst` = 0;
  - `req_valid[i]` = 1;
  - i is the first requester with `req_valid` set, searching circularly from `rr_ptr`.
- `req_ready` does not depend on `req_valid` of the granted requester beyond the search above, so it is not a combinational loop back to that requester.
- A transfer occurs when `req_valid[i] & req_ready[i]`. On the following edge:
  - `mul_a`/`mul_b` load operands i;
  - `mul_en` = 1;
  - the issue tag {valid=1, id=i} loads;
  - `rr_ptr` moves to (i+1) mod NUM_REQ.
- With no transfer, `mul_en` = 0 and `rr_ptr` holds. `mul_a`/`mul_b` also hold, to limit toggling.
- The tag pipeline has `MULT_LATENCY` stages after the issue tag. It shifts every cycle unconditionally, because the multiplier has no stall.
- Response path is combinational from the tag tail and the multiplier outputs:
  - `rsp_valid` = tail.valid ? onehot(tail.id) : 0;
  - `rsp_result` = `mul_result`; `rsp_flags` = `mul_flags`; `rsp_id` = tail.id.
- `sync_err` sets when `mul_valid` != tail.valid. It clears only on `rst`.
- `inflight` counts accepted operations not yet returned:
  - increments when a transfer occurs;
  - decrements when tail.valid = 1;
  - is unchanged when both happen in the same cycle.
- The maximum value of `inflight` is MULT_LATENCY+1.
- Responses have no backpressure. Requesters must always sink `rsp_valid`.

## Timing
- Reset values: `req_ready`=0, `mul_en`=0, `mul_a`=`mul_b`=0, all tag valids 0, `rr_ptr`=0, `rsp_valid`=0, `rsp_id`=0, `inflight`=0, `sync_err`=0.
- Latency: transfer in cycle T → `mul_en` high in T+1 → `rsp_valid` high in T+1+MULT_LATENCY (T+4 by default).
- Throughput is one operation per cycle. Back-to-back grants are allowed, including to the same requester when it is the only one valid.
- Fairness: under continuous requests from all NUM_REQ requesters, grants rotate 0,1,…,NUM_REQ-1. No requester waits more than NUM_REQ-1 cycles.
- Deasserting `arb_en` mid-stream:
  - the grant stops in the same cycle;
  - operations already accepted complete on schedule;
  - `rr_ptr` holds.
- `rst` mid-operation:
  - all tags are discarded, so no `rsp_valid` is produced for ops in flight;
  - the multiplier shares `rst`, so its pipeline also empties;
  - `sync_err` must stay 0 across the reset.
- A requester that drops `req_valid` without being granted is legal. No state changes.

## Test plan
- Single op: req 2 sends a=3E00, b=4000 at T.
  - `req_ready`=0100 at T; `mul_en` at T+1;
  - `rsp_valid`=0100, `rsp_result`=4200, `rsp_id`=2 at T+4.
- All four requesters continuously valid for 8 cycles from reset:
  - grants 0,1,2,3,0,1,2,3;
  - responses return in the same order, 4 cycles later;
  - `inflight` saturates at 4.
- Only req 1 valid for 5 cycles, then req 3 joins: 5 consecutive grants to 1, then alternating 3,1.
- `arb_en` low for 2 cycles with requests pending:
  - no `req_ready` and no `mul_en` during those cycles;
  - ops already in flight still return;
  - granting resumes from the held `rr_ptr`.
- Assert `rst` for 1 cycle with 3 ops in flight: no `rsp_valid` afterwards, `inflight`=0, `sync_err`=0.
- Multiplier model injects a spurious `mul_valid` with no tag valid: `sync_err`=1 next cycle and stays 1 until `rst`.
